// File: rtl/systolic_edge_feeder_if.sv
// Operand stream into the systolic edge feeder: one k-step (A column, B row) per beat.
// Handshake: a beat transfers on a rising edge where valid && ready; the source
// holds valid, a, b and last stable until that edge, and ready never depends on valid.
interface systolic_edge_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
);
  logic                    valid;
  logic                    ready;
  logic [N*DATA_WIDTH-1:0] a;
  logic [N*DATA_WIDTH-1:0] b;
  logic                    last;

  modport master (output valid, a, b, last, input ready);
  modport slave  (input valid, a, b, last, output ready);
endinterface

// File: rtl/systolic_edge_feeder.sv
// Edge feeder for an N x N MAC mesh: skews lane i of each accepted k-step by i
// cycles, clears the accumulators before a job and pulses done when results are final.
module systolic_edge_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  systolic_edge_feeder_if.slave   s,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    pe_clr,
  output logic                    done,
  output logic [2:0]              state_dbg
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = $clog2(2 * N) + 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] flush_cnt;
  logic          take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = FEED;
      FEED:    if (take && s.last) state_next = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign take      = s.valid && (state == FEED);
  assign s.ready   = (state == FEED);
  assign busy      = (state != IDLE);
  assign pe_clr    = (state == CLEAR);
  assign done      = (state == DONE);
  assign state_dbg = state;

  // Cycles without a beat push zeros, so bubbles contribute nothing to the products.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_st [0:i];
    logic [DATA_WIDTH-1:0] b_st [0:i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= i; k++) begin
          a_st[k] <= '0;
          b_st[k] <= '0;
        end
      end else begin
        a_st[0] <= take ? s.a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_st[0] <= take ? s.b[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) begin
          a_st[k] <= a_st[k-1];
          b_st[k] <= b_st[k-1];
        end
      end
    end

    assign a_edge[i*DATA_WIDTH +: DATA_WIDTH] = a_st[i];
    assign b_edge[i*DATA_WIDTH +: DATA_WIDTH] = b_st[i];
  end
endmodule

// File: tb/tb_systolic_edge_feeder.sv
// Bench for systolic_edge_feeder: timestamp model of the expected edges and control,
// plus a MAC mesh driven by the edges whose results are compared with a matrix product.
module tb_systolic_edge_feeder;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int W    = N * DW;
  localparam int ACC  = 2 * DW + 1;
  localparam int CW   = N * N * ACC;
  localparam int KMAX = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         busy, pe_clr, done;
  logic [W-1:0] a_edge, b_edge;
  logic [2:0]   state_dbg;

  systolic_edge_feeder_if #(.DATA_WIDTH(DW), .N(N)) s_if ();

  systolic_edge_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .s         (s_if.slave),
    .a_edge    (a_edge),
    .b_edge    (b_edge),
    .pe_clr    (pe_clr),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [CW-1:0] exp_q[$];
  int            mat_a [N][KMAX];
  int            mat_b [KMAX][N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [CW-1:0] matmul(input int k);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int sum;
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += mat_a[i][kk] * mat_b[kk][j];
        r[(i*N+j)*ACC +: ACC] = ACC'(sum);
      end
    return r;
  endfunction

  // ---------------- mesh harness driven by the edges ----------------
  logic [DW-1:0]  ma [N][N];
  logic [DW-1:0]  mb [N][N];
  logic [ACC-1:0] mc [N][N];
  logic [DW-1:0]  pa_in [N][N];
  logic [DW-1:0]  pb_in [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a0
        assign pa_in[i][j] = a_edge[i*DW +: DW];
      end else begin : g_an
        assign pa_in[i][j] = ma[i][j-1];
      end
      if (i == 0) begin : g_b0
        assign pb_in[i][j] = b_edge[j*DW +: DW];
      end else begin : g_bn
        assign pb_in[i][j] = mb[i-1][j];
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] <= '0;
          mb[i][j] <= '0;
          mc[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] <= pa_in[i][j];
          mb[i][j] <= pb_in[i][j];
          mc[i][j] <= pe_clr ? '0 : mc[i][j] + ACC'(pa_in[i][j]) * ACC'(pb_in[i][j]);
        end
    end
  end

  // ---------------- reference model (job timestamps + beat log) ----------------
  bit           in_job = 0;
  int           start_c = 0;
  int           last_c = -1;
  bit           model_take = 0;
  logic [W-1:0] log_a [int];
  logic [W-1:0] log_b [int];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready", s_if.ready, 0);
      chk("rst_clr", pe_clr, 0);
      chk("rst_done", done, 0);
      chk("rst_a_edge", a_edge, 0);
      chk("rst_b_edge", b_edge, 0);
      in_job = 0;
      last_c = -1;
      model_take = 0;
      log_a.delete();
      log_b.delete();
      exp_q.delete();
    end else begin
      int c;
      bit was_in_job, e_busy, e_clr, e_feed, e_done;
      logic [W-1:0] ea, eb, t;
      c          = cyc;
      was_in_job = in_job;
      e_busy = in_job && (c > start_c);
      e_clr  = in_job && (c == start_c + 1);
      e_feed = in_job && (c >= start_c + 2) && (last_c < 0 || c <= last_c);
      e_done = in_job && (last_c >= 0) && (c == last_c + 2 * N);
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        if (log_a.exists(c - 1 - i)) begin
          t = log_a[c-1-i];
          ea[i*DW +: DW] = t[i*DW +: DW];
          t = log_b[c-1-i];
          eb[i*DW +: DW] = t[i*DW +: DW];
        end
      end
      chk("busy", busy, e_busy);
      chk("s_ready", s_if.ready, e_feed);
      chk("pe_clr", pe_clr, e_clr);
      chk("done", done, e_done);
      chk("a_edge", a_edge, ea);
      chk("b_edge", b_edge, eb);

      model_take = e_feed && s_if.valid;
      if (model_take) begin
        log_a[c] = s_if.a;
        log_b[c] = s_if.b;
        if (s_if.last) last_c = c;
      end
      if (e_done) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 1, 0);
        end else begin
          logic [CW-1:0] ec;
          ec = exp_q.pop_front();
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              chk($sformatf("c_%0d_%0d", i, j), mc[i][j], ec[(i*N+j)*ACC +: ACC]);
        end
        in_job = 0;
        last_c = -1;
      end
      if (!was_in_job && start) begin
        in_job  = 1;
        start_c = c;
        last_c  = -1;
      end
    end
  end

  // ---------------- driver tasks (entered #1 after a rising edge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input int k, input bit last, input bit poke);
    logic [W-1:0] va, vb;
    int guard;
    for (int i = 0; i < N; i++) begin
      va[i*DW +: DW] = DW'(mat_a[i][k]);
      vb[i*DW +: DW] = DW'(mat_b[k][i]);
    end
    s_if.valid = 1'b1;
    s_if.a     = va;
    s_if.b     = vb;
    s_if.last  = last;
    start      = poke;
    guard      = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (!model_take && guard < 40);
    if (!model_take) chk("beat_timeout", 0, 1);
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.a     = W'($urandom);
    s_if.b     = W'($urandom);
    start      = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (in_job && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (in_job) chk("done_timeout", 0, 1);
    #1;
  endtask

  task automatic run_job(input int k, input int bub_lo, input int bub_hi, input bit poke);
    exp_q.push_back(matmul(k));
    pulse_start();
    for (int kk = 0; kk < k; kk++) begin
      if (kk > 0) begin
        int r;
        r = $urandom_range(bub_hi, bub_lo);
        if (r > 0) begin
          repeat (r) @(posedge clk);
          #1;
        end
      end
      send_beat(kk, kk == k - 1, poke && kk == 0);
    end
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_idle();
  endtask

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) begin
        mat_a[i][k] = 0;
        mat_b[k][i] = 0;
      end
  endtask

  task automatic rand_mats(input int k, input int hi);
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < k; kk++) begin
        mat_a[i][kk] = $urandom_range(hi, 0);
        mat_b[kk][i] = $urandom_range(hi, 0);
      end
  endtask

  task automatic load_2x2();
    clear_mats();
    mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[1][0] = 3; mat_a[1][1] = 4;
    mat_b[0][0] = 5; mat_b[0][1] = 6; mat_b[1][0] = 7; mat_b[1][1] = 8;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    s_if.valid = 1'b0;
    s_if.a     = '0;
    s_if.b     = '0;
    s_if.last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 2x2 product in the top-left corner of the mesh, then the same job with bubbles
    load_2x2();
    run_job(2, 0, 0, 0);
    chk("c00_direct", mc[0][0], 19);
    chk("c01_direct", mc[0][1], 22);
    chk("c10_direct", mc[1][0], 43);
    chk("c11_direct", mc[1][1], 50);
    run_job(2, 3, 3, 0);
    chk("c11_bubble", mc[1][1], 50);

    // identity job started the cycle after done: old results must be cleared
    clear_mats();
    for (int i = 0; i < N; i++) begin
      mat_a[i][i] = 1;
      mat_b[i][i] = 1;
    end
    run_job(N, 0, 0, 0);
    chk("c00_ident", mc[0][0], 1);
    chk("c01_ident", mc[0][1], 0);

    // randomized jobs, some with start pulses during FEED and FLUSH
    for (int n = 0; n < 12; n++) begin
      int k;
      k = $urandom_range(6, 1);
      rand_mats(k, 100);
      run_job(k, 0, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    // reset in the middle of FEED with nonzero lanes
    rand_mats(2, 200);
    for (int i = 0; i < N; i++) mat_a[i][0] = $urandom_range(255, 1);
    pulse_start();
    send_beat(0, 1'b0, 1'b0);
    chk("pre_rst_lane0", a_edge[DW-1:0], DW'(mat_a[0][0]));
    #1 rst = 1'b0;
    #1;
    chk("rst_now_a", a_edge, 0);
    chk("rst_now_b", b_edge, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_ready", s_if.ready, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    // valid beats in IDLE must not be taken
    s_if.valid = 1'b1;
    s_if.a     = W'($urandom);
    s_if.b     = W'($urandom);
    repeat (4) @(posedge clk);
    #1 s_if.valid = 1'b0;

    // recovery after the aborted job
    rand_mats(3, 100);
    run_job(3, 0, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/systolic_edge_feeder.md
Name: systolic_edge_feeder

Overview:
- Transmit side of the processing-element mesh: drives the left edge (A operand) and top edge (B operand) of an N x N grid of multiply-accumulate PEs.
- Accepts one k-step per beat: a column of A and a row of B, N lanes each. Re-times lane i by i cycles to create the diagonal wavefront the mesh needs.
- Issues the accumulator clear before each job and a done pulse once every PE result is final.

Parameters:
- DATA_WIDTH, 8, operand width per lane.
- N, 4, mesh dimension (lanes per edge), >= 2.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low: asserted (0) forces reset immediately; deassertion is synchronous to clk.
- start  input  1  request a new job; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- s_valid  input  1  beat present on s_a/s_b/s_last.
- s_ready  output  1  feeder accepts the beat this cycle.
- s_a  input  N*DATA_WIDTH  A column k; lane i = bits [i*DW +: DW] = A[i][k].
- s_b  input  N*DATA_WIDTH  B row k; lane j = B[k][j].
- s_last  input  1  marks the final k-step of the job.
- a_edge  output  N*DATA_WIDTH  to a_in of row i, column 0 PE (lane i).
- b_edge  output  N*DATA_WIDTH  to b_in of row 0, column j PE (lane j).
- pe_clr  output  1  active-high synchronous clear for the mesh accumulators.
- done  output  1  one-cycle pulse: all mesh results final.

Behaviour:
- Reset: state=IDLE. busy, s_ready, pe_clr and done are 0. a_edge, b_edge and all skew stages are 0.
- FSM: IDLE -> CLEAR -> FEED -> FLUSH -> DONE -> IDLE.
- IDLE: s_ready=0. start=1 -> CLEAR.
- CLEAR: exactly one cycle. pe_clr=1, edges 0, s_ready=0. Always moves to FEED.
- FEED: s_ready=1. A beat is accepted when s_valid && s_ready.
  - Accepted beat: lane i of s_a/s_b enters skew line i.
  - No beat this cycle: an all-zero vector enters every skew line. This bubble adds zero to every product, so alignment is kept; stalls are legal anywhere in a job.
  - Accepted beat with s_last=1 -> FLUSH. s_ready drops in the next cycle.
- Skew timing: skew line i is a 1-cycle output register plus i further register stages. A beat accepted in cycle T appears on lane i of a_edge and b_edge in cycle T+1+i.
- FLUSH: s_ready=0; zeros are fed into all lanes. Lasts 2N-1 cycles, counted by an internal counter of width clog2(2N)+1, which resets on entry.
- DONE: done=1 for one cycle, in cycle T_last+2N, where T_last is the cycle the s_last beat was accepted. Then -> IDLE.
  - Mesh PE(i,j) sees the last operands in cycle T_last+1+i+j, so its c_out is final by T_last+2N.
- A job may have any number K >= 1 of beats. There is no internal K count; s_last alone ends the job.
- start outside IDLE is ignored and is not queued.
- s_valid outside FEED is not accepted; the source must hold the beat until FEED.
- Reset during FEED or FLUSH aborts the job: outputs zero immediately, and no done pulse is issued for the aborted job.
- The feeder holds no arithmetic. The mesh accumulator width (2*DATA_WIDTH+1) must hold K products; choosing K so it does not overflow is the user's responsibility.

Test Plan:
- Reset: hold rst=0 mid-FEED with nonzero lanes -> a_edge=b_edge=0, busy=0, s_ready=0 within the same cycle. After release the block sits in IDLE and ignores s_valid.
- Skew, N=2: start, then beat A col=(1,3), B row=(5,6) accepted at T -> a_edge lane0=1 and b_edge lane0=5 at T+1; lane1 a=3, b=6 at T+2; lanes 0 elsewhere.
- Full job with a 2x2 mesh, N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats k=0,1, s_last on k=1 -> pe_clr one cycle before first s_ready; done at T_last+4; mesh C=[[19,22],[43,50]].
- Bubble: same job with s_valid=0 for 3 cycles between beats -> identical C, and done moves 3 cycles later.
- Back-to-back jobs: second start the cycle after done, with A=B=identity -> pe_clr clears the old results; C=identity; no leftover from the first job.
- Ignored inputs: start pulsed during FEED and FLUSH -> exactly one done and no extra CLEAR. s_valid=1 in IDLE -> s_ready=0 and the edges stay 0.
